return_stack: RTL



---
 rtl/return_stack.sv | 120 ++++++++++++
 1 files changed

// File: rtl/return_stack.sv
// Circular return-address stack for the program counter (PIC16-style).
// Overflow overwrites the oldest entry; popping an empty stack still wraps the pointer.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              push_addr,
  input  logic                       clear_flags,
  output logic [AW-1:0]              ret_addr,
  output logic                       ret_valid,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [DW-1:0] r_depth;
  logic [AW-1:0] r_ret_addr;
  logic          r_ret_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_push_only;
  logic          w_pop_only;
  logic          w_both;
  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_sp_m1;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;

  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_both      = push & pop;
  assign w_empty     = (r_depth == '0);
  assign w_full      = (r_depth == DW'(DEPTH));
  assign w_sp_m1     = r_sp - PW'(1);

  // Simultaneous push/pop on a non-empty stack rewrites the top in place.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = r_sp;
    if (w_push_only) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_sp;
    end else if (w_both && !w_empty) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_sp_m1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_depth <= '0;
    end else if (w_push_only) begin
      r_sp <= r_sp + PW'(1);
      if (!w_full) begin
        r_depth <= r_depth + DW'(1);
      end
    end else if (w_pop_only) begin
      r_sp <= w_sp_m1;
      if (!w_empty) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret_addr  <= '0;
      r_ret_valid <= 1'b0;
    end else begin
      r_ret_valid <= pop;
      if (pop) begin
        r_ret_addr <= (push && w_empty) ? push_addr : r_mem[w_sp_m1];
      end
    end
  end

  // A set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (w_push_only & w_full) | (r_overflow & ~clear_flags);
      r_underflow <= (pop & w_empty) | (r_underflow & ~clear_flags);
    end
  end

  assign ret_addr  = r_ret_addr;
  assign ret_valid = r_ret_valid;
  assign depth     = r_depth;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
